// File: rtl/i2c_command_sequencer_pkg.sv
// Shared types for the I2C command sequencer: FSM states, queued command
// layout and watchdog sizing.
package i2c_command_sequencer_pkg;

    // Field widths of a queued command. The top-level width parameters
    // default to these values and must match them, because command_t fixes
    // the field layout stored in the FIFO.
    localparam int unsigned CmdDataWidth     = 8;
    localparam int unsigned CmdRegisterWidth = 8;
    localparam int unsigned CmdAddressWidth  = 7;

    // Watchdog counter width.
    localparam int unsigned TimeoutWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StActive,
        StRespond
    } seq_state_e;

    typedef struct packed {
        logic                        rw;
        logic [CmdAddressWidth-1:0]  device;
        logic [CmdRegisterWidth-1:0] register_addr;
        logic [CmdDataWidth-1:0]     data;
    } command_t;

    // Saturating increment so a stuck phase never wraps back to zero.
    function automatic logic [TimeoutWidth-1:0] watchdog_next(
        input logic [TimeoutWidth-1:0] value
    );
        if (value == {TimeoutWidth{1'b1}}) begin
            return value;
        end
        return value + {{(TimeoutWidth-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/i2c_command_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without an occupancy counter.
module i2c_command_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);
    localparam int unsigned PtrWidth  = AddrWidth + 1;
    localparam logic [PtrWidth-1:0] PtrOne = {{(PtrWidth-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic                w_push;
    logic                w_pop;

    assign o_full  = (r_wr_ptr[PtrWidth-1] != r_rd_ptr[PtrWidth-1]) &&
                     (r_wr_ptr[AddrWidth-1:0] == r_rd_ptr[AddrWidth-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head entry is presented combinationally; no fall-through from push.
    assign o_pop_data = r_mem[r_rd_ptr[AddrWidth-1:0]];

    // Pointer update; reset flushes the queue by equalising the pointers.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AddrWidth-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/i2c_command_sequencer.sv
// Front-end for i2c_master: queues register-access commands, launches them
// one at a time, watches the master's busy handshake and returns one
// response per command, flagging a timeout if a phase stalls.
module i2c_command_sequencer
    import i2c_command_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = CmdDataWidth,
    parameter int unsigned REGISTER_WIDTH = CmdRegisterWidth,
    parameter int unsigned ADDRESS_WIDTH  = CmdAddressWidth,
    parameter int unsigned COMMAND_DEPTH  = 4,
    parameter logic [TimeoutWidth-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      command_valid,
    output logic                      command_ready,
    input  logic                      command_read_write,
    input  logic [ADDRESS_WIDTH-1:0]  command_device_address,
    input  logic [REGISTER_WIDTH-1:0] command_register_address,
    input  logic [DATA_WIDTH-1:0]     command_data,
    input  logic [15:0]               divider,
    output logic                      response_valid,
    input  logic                      response_ready,
    output logic                      response_read_write,
    output logic [DATA_WIDTH-1:0]     response_data,
    output logic                      response_timeout,
    output logic                      sequencer_busy,
    output logic                      master_enable,
    output logic                      master_read_write,
    output logic [DATA_WIDTH-1:0]     master_mosi_data,
    output logic [REGISTER_WIDTH-1:0] master_register_address,
    output logic [ADDRESS_WIDTH-1:0]  master_device_address,
    output logic [15:0]               master_divider,
    input  logic [DATA_WIDTH-1:0]     master_miso_data,
    input  logic                      master_busy
);

    // Last watchdog value before expiry: a phase gets exactly
    // TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES must be at least 1).
    localparam logic [TimeoutWidth-1:0] WatchdogLast = TIMEOUT_CYCLES - 16'd1;

    seq_state_e                r_state;
    logic [TimeoutWidth-1:0]   r_watchdog;
    logic                      r_response_valid;
    logic                      r_response_read_write;
    logic [DATA_WIDTH-1:0]     r_response_data;
    logic                      r_response_timeout;
    logic                      r_master_enable;
    logic                      r_master_read_write;
    logic [DATA_WIDTH-1:0]     r_master_mosi_data;
    logic [REGISTER_WIDTH-1:0] r_master_register_address;
    logic [ADDRESS_WIDTH-1:0]  r_master_device_address;
    logic [15:0]               r_master_divider;

    command_t w_push_cmd;
    command_t w_head_cmd;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_fifo_push;
    logic     w_fifo_pop;
    logic     w_watchdog_expired;

    assign w_push_cmd.rw            = command_read_write;
    assign w_push_cmd.device        = command_device_address;
    assign w_push_cmd.register_addr = command_register_address;
    assign w_push_cmd.data          = command_data;

    assign command_ready      = !w_fifo_full;
    assign w_fifo_push        = command_valid && command_ready;
    assign w_fifo_pop         = (r_state == StIdle) && !w_fifo_empty;
    assign w_watchdog_expired = (r_watchdog >= WatchdogLast);

    i2c_command_fifo #(
        .DEPTH (COMMAND_DEPTH),
        .WIDTH ($bits(command_t))
    ) u_command_fifo (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_push      (w_fifo_push),
        .i_push_data (w_push_cmd),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (w_head_cmd),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Sequencer FSM with watchdog, response register and master outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state                   <= StIdle;
            r_watchdog                <= '0;
            r_response_valid          <= 1'b0;
            r_response_read_write     <= 1'b0;
            r_response_data           <= '0;
            r_response_timeout        <= 1'b0;
            r_master_enable           <= 1'b0;
            r_master_read_write       <= 1'b0;
            r_master_mosi_data        <= '0;
            r_master_register_address <= '0;
            r_master_device_address   <= '0;
            r_master_divider          <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_fifo_empty) begin
                        r_master_read_write       <= w_head_cmd.rw;
                        r_master_device_address   <= w_head_cmd.device;
                        r_master_register_address <= w_head_cmd.register_addr;
                        r_master_mosi_data        <= w_head_cmd.data;
                        r_master_divider          <= divider;
                        r_master_enable           <= 1'b1;
                        r_watchdog                <= '0;
                        r_state                   <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (master_busy) begin
                        r_master_enable <= 1'b0;
                        r_watchdog      <= '0;
                        r_state         <= StActive;
                    end else if (w_watchdog_expired) begin
                        // Master never started: answer with a timeout.
                        r_master_enable       <= 1'b0;
                        r_response_valid      <= 1'b1;
                        r_response_read_write <= r_master_read_write;
                        r_response_data       <= '0;
                        r_response_timeout    <= 1'b1;
                        r_watchdog            <= '0;
                        r_state               <= StRespond;
                    end else begin
                        r_watchdog <= watchdog_next(r_watchdog);
                    end
                end
                StActive: begin
                    if (!master_busy) begin
                        r_response_valid      <= 1'b1;
                        r_response_read_write <= r_master_read_write;
                        r_response_data       <= r_master_read_write ? master_miso_data : '0;
                        r_response_timeout    <= 1'b0;
                        r_watchdog            <= '0;
                        r_state               <= StRespond;
                    end else if (w_watchdog_expired) begin
                        r_response_valid      <= 1'b1;
                        r_response_read_write <= r_master_read_write;
                        r_response_data       <= '0;
                        r_response_timeout    <= 1'b1;
                        r_watchdog            <= '0;
                        r_state               <= StRespond;
                    end else begin
                        r_watchdog <= watchdog_next(r_watchdog);
                    end
                end
                StRespond: begin
                    if (response_ready) begin
                        r_response_valid <= 1'b0;
                        r_watchdog       <= '0;
                        r_state          <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign sequencer_busy          = (r_state != StIdle) || !w_fifo_empty;
    assign response_valid          = r_response_valid;
    assign response_read_write     = r_response_read_write;
    assign response_data           = r_response_data;
    assign response_timeout        = r_response_timeout;
    assign master_enable           = r_master_enable;
    assign master_read_write       = r_master_read_write;
    assign master_mosi_data        = r_master_mosi_data;
    assign master_register_address = r_master_register_address;
    assign master_device_address   = r_master_device_address;
    assign master_divider          = r_master_divider;

endmodule
